// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin CPU/debug arbiter for the single external memory port
// One transaction at a time: grant in IDLE, one-cycle strobe, optional read wait, one-cycle ack.
module mem_bus_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [7:0]  i_cpu_addr,
  input  logic [15:0] i_cpu_wdata,
  output logic        o_cpu_ack,
  output logic [15:0] o_cpu_rdata,
  input  logic        i_dbg_req,
  input  logic        i_dbg_we,
  input  logic [7:0]  i_dbg_addr,
  input  logic [15:0] i_dbg_wdata,
  output logic        o_dbg_ack,
  output logic [15:0] o_dbg_rdata,
  output logic [7:0]  o_mem_addr,
  output logic [15:0] o_mem_wdata,
  output logic        o_mem_we,
  output logic        o_mem_re,
  input  logic [15:0] i_mem_rdata,
  output logic        o_busy,
  output logic        o_owner
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        last_owner_q, last_owner_d;
  logic        owner_q, owner_d;
  logic        txn_we_q, txn_we_d;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_re_q, mem_re_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        dbg_ack_q, dbg_ack_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] dbg_rdata_q, dbg_rdata_d;
  logic        busy_q, busy_d;
  logic        grant_dbg;
  logic        win_we;

  // Debug wins when it is the only requester, or on a tie when CPU was granted last.
  assign grant_dbg = i_dbg_req && (!i_cpu_req || !last_owner_q);
  assign win_we    = grant_dbg ? i_dbg_we : i_cpu_we;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    txn_we_d     = txn_we_q;
    mem_addr_d   = mem_addr_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    busy_d       = busy_q;
    mem_wdata_d  = 16'h0000;
    mem_we_d     = 1'b0;
    mem_re_d     = 1'b0;
    cpu_ack_d    = 1'b0;
    dbg_ack_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_cpu_req || i_dbg_req) begin
          owner_d      = grant_dbg;
          last_owner_d = grant_dbg;
          txn_we_d     = win_we;
          mem_addr_d   = grant_dbg ? i_dbg_addr : i_cpu_addr;
          mem_we_d     = win_we;
          mem_re_d     = !win_we;
          if (win_we) mem_wdata_d = grant_dbg ? i_dbg_wdata : i_cpu_wdata;
          busy_d       = 1'b1;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (txn_we_q) begin
          cpu_ack_d = !owner_q;
          dbg_ack_d = owner_q;
          state_d   = S_DONE;
        end else begin
          cnt_d   = 3'd1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'(RD_LAT)) begin
          if (owner_q) dbg_rdata_d = i_mem_rdata;
          else         cpu_rdata_d = i_mem_rdata;
          cpu_ack_d = !owner_q;
          dbg_ack_d = owner_q;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        cnt_d   = 3'd0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      txn_we_q     <= 1'b0;
      mem_addr_q   <= 8'h00;
      mem_wdata_q  <= 16'h0000;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      cpu_ack_q    <= 1'b0;
      dbg_ack_q    <= 1'b0;
      cpu_rdata_q  <= 16'h0000;
      dbg_rdata_q  <= 16'h0000;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      txn_we_q     <= txn_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      cpu_ack_q    <= cpu_ack_d;
      dbg_ack_q    <= dbg_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign o_cpu_ack   = cpu_ack_q;
  assign o_dbg_ack   = dbg_ack_q;
  assign o_cpu_rdata = cpu_rdata_q;
  assign o_dbg_rdata = dbg_rdata_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_re    = mem_re_q;
  assign o_busy      = busy_q;
  assign o_owner     = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed bench for mem_bus_arbiter (RD_LAT=1 and RD_LAT=3 instances)
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
  logic [7:0]  cpu_addr = 0, dbg_addr = 0;
  logic [15:0] cpu_wdata = 0, dbg_wdata = 0;
  logic        cpu_ack, dbg_ack, mem_we, mem_re, busy, owner;
  logic [15:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;

  mem_bus_arbiter #(.RD_LAT(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_ack(dbg_ack), .o_dbg_rdata(dbg_rdata),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we), .o_mem_re(mem_re),
    .i_mem_rdata(mem_rdata), .o_busy(busy), .o_owner(owner)
  );

  // RAM model, RD_LAT=1: data valid only in the cycle after the read strobe
  logic [15:0] ram [0:255];
  logic [15:0] rd_pipe1 = 0;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    rd_pipe1 <= mem_re ? ram[mem_addr] : 16'h0000;
  end
  assign mem_rdata = rd_pipe1;

  logic        d3_cpu_req = 0, d3_dbg_req = 0;
  logic [7:0]  d3_dbg_addr = 0;
  logic        d3_cpu_ack, d3_dbg_ack, d3_mem_we, d3_mem_re, d3_busy, d3_owner;
  logic [15:0] d3_cpu_rdata, d3_dbg_rdata, d3_mem_wdata, d3_mem_rdata;
  logic [7:0]  d3_mem_addr;

  mem_bus_arbiter #(.RD_LAT(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_req(d3_cpu_req), .i_cpu_we(1'b0), .i_cpu_addr(8'h00), .i_cpu_wdata(16'h0000),
    .o_cpu_ack(d3_cpu_ack), .o_cpu_rdata(d3_cpu_rdata),
    .i_dbg_req(d3_dbg_req), .i_dbg_we(1'b0), .i_dbg_addr(d3_dbg_addr), .i_dbg_wdata(16'h0000),
    .o_dbg_ack(d3_dbg_ack), .o_dbg_rdata(d3_dbg_rdata),
    .o_mem_addr(d3_mem_addr), .o_mem_wdata(d3_mem_wdata), .o_mem_we(d3_mem_we), .o_mem_re(d3_mem_re),
    .i_mem_rdata(d3_mem_rdata), .o_busy(d3_busy), .o_owner(d3_owner)
  );

  // RAM model, RD_LAT=3: contents are 0x5A00|addr, valid only 3 cycles after the strobe
  logic [15:0] p0 = 0, p1 = 0, p2 = 0;
  always @(posedge clk) begin
    p0 <= d3_mem_re ? (16'h5A00 | {8'h00, d3_mem_addr}) : 16'h0000;
    p1 <= p0;
    p2 <= p1;
  end
  assign d3_mem_rdata = p2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if ((cpu_ack && dbg_ack) || (mem_we && mem_re) || (cpu_ack && owner) || (dbg_ack && !owner) ||
          (d3_cpu_ack && d3_dbg_ack) || (d3_mem_we && d3_mem_re)) begin
        bad++;
        $display("FAIL exclusivity at %0t: acks=%b%b owner=%b strobes=%b%b, want at most one of each and ack matching owner",
                 $time, cpu_ack, dbg_ack, owner, mem_we, mem_re);
      end
    end
  end

  task automatic do_txn(input logic dbg, input logic we, input logic [7:0] addr, input logic [15:0] wd,
                        input logic [15:0] exp_rd, input int exp_lat, input string nm);
    logic [15:0] c0, d0;
    int n;
    bit got;
    c0 = cpu_rdata;
    d0 = dbg_rdata;
    if (dbg) begin dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd; end
    else     begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
    got = 0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({nm, "_we"}, mem_we, we);
        chk({nm, "_re"}, mem_re, !we);
        chk({nm, "_addr"}, mem_addr, addr);
        chk({nm, "_wdata"}, mem_wdata, we ? wd : 16'h0000);
        chk({nm, "_busy"}, busy, 1);
        chk({nm, "_owner"}, owner, dbg);
      end else if (!cpu_ack && !dbg_ack) begin
        chk({nm, "_nostrobe"}, {mem_we, mem_re}, 2'b00);
      end
      if (cpu_ack || dbg_ack) got = 1;
    end
    chk({nm, "_lat"}, n, exp_lat);
    chk({nm, "_ackwho"}, {cpu_ack, dbg_ack}, dbg ? 2'b01 : 2'b10);
    cpu_req = 0;
    dbg_req = 0;
    @(negedge clk);
    chk({nm, "_ackpulse"}, {cpu_ack, dbg_ack, busy}, 3'b000);
    chk({nm, "_cpu_rdata"}, cpu_rdata, (!dbg && !we) ? exp_rd : c0);
    chk({nm, "_dbg_rdata"}, dbg_rdata, (dbg && !we) ? exp_rd : d0);
  endtask

  typedef struct {
    logic        dbg;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wd;
    logic [15:0] rd;
    int          lat;
  } vec_t;

  vec_t vt[7];
  logic order [4];
  int   when [4];
  int   nack, cyc, n;

  initial begin
    vt[0] = '{0, 1, 8'h12, 16'hBEEF, 16'h0000, 2};
    vt[1] = '{1, 0, 8'h12, 16'h0000, 16'hBEEF, 3};
    vt[2] = '{1, 1, 8'h00, 16'h1234, 16'h0000, 2};
    vt[3] = '{0, 0, 8'h00, 16'h0000, 16'h1234, 3};
    vt[4] = '{0, 1, 8'hFF, 16'hA5A5, 16'h0000, 2};
    vt[5] = '{1, 0, 8'hFF, 16'h0000, 16'hA5A5, 3};
    vt[6] = '{0, 0, 8'h12, 16'h0000, 16'hBEEF, 3};

    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_flags", {cpu_ack, dbg_ack, mem_we, mem_re, busy, owner}, 6'b0);
    chk("rst_data", {cpu_rdata, dbg_rdata, mem_wdata, mem_addr}, 56'h0);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", {busy, mem_we, mem_re, cpu_ack, dbg_ack}, 5'b0);

    for (int i = 0; i < 7; i++)
      do_txn(vt[i].dbg, vt[i].we, vt[i].addr, vt[i].wd, vt[i].rd, vt[i].lat, $sformatf("vec%0d", i));

    // Both requesters held: alternate starting with CPU, one write every 3 cycles
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h20; cpu_wdata = 16'h1111;
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h21; dbg_wdata = 16'h2222;
    nack = 0;
    cyc = 0;
    while (nack < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cpu_ack || dbg_ack) begin
        order[nack] = dbg_ack;
        when[nack] = cyc;
        nack++;
      end
    end
    cpu_req = 0;
    dbg_req = 0;
    chk("rr_count", nack, 4);
    for (int i = 0; i < nack; i++) begin
      chk($sformatf("rr_order%0d", i), order[i], i % 2);
      if (i > 0) chk($sformatf("rr_gap%0d", i), when[i] - when[i-1], 3);
    end
    repeat (2) @(negedge clk);

    // CPU held, debug raised mid CPU transaction: debug takes the next grant
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h30; cpu_wdata = 16'h3333;
    @(negedge clk);
    chk("starve_busy", busy, 1);
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h31; dbg_wdata = 16'h4444;
    nack = 0;
    cyc = 0;
    while (nack < 2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cpu_ack || dbg_ack) begin
        order[nack] = dbg_ack;
        nack++;
      end
    end
    cpu_req = 0;
    dbg_req = 0;
    chk("starve_count", nack, 2);
    chk("starve_first", order[0], 0);
    chk("starve_second", order[1], 1);
    repeat (2) @(negedge clk);
    chk("starve_idle", busy, 0);

    // Reset during WAIT of a CPU read
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h12;
    @(negedge clk);
    chk("rstw_access_re", mem_re, 1);
    @(negedge clk);
    chk("rstw_in_wait", {busy, mem_re, cpu_ack}, 3'b100);
    rst_n = 0;
    cpu_req = 0;
    @(negedge clk);
    chk("rstw_flags", {cpu_ack, dbg_ack, mem_we, mem_re, busy, owner}, 6'b0);
    chk("rstw_data", {cpu_rdata, dbg_rdata, mem_wdata, mem_addr}, 56'h0);
    @(negedge clk);
    chk("rstw_noack", {cpu_ack, dbg_ack}, 2'b00);
    rst_n = 1;
    @(negedge clk);
    do_txn(0, 0, 8'h12, 16'h0000, 16'hBEEF, 3, "post_rst_rd");

    // RD_LAT=3 instance: debug read, request dropped in k+2
    d3_dbg_addr = 8'h40;
    d3_dbg_req = 1;
    n = 0;
    cyc = 0;
    while (n == 0 && cyc < 15) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("lat3_re", d3_mem_re, 1);
        chk("lat3_addr", d3_mem_addr, 8'h40);
      end
      if (cyc == 2) d3_dbg_req = 0;
      if (cyc == 4) chk("lat3_not_yet", d3_dbg_rdata, 16'h0000);
      if (d3_dbg_ack) n = cyc;
    end
    chk("lat3_ack_cycle", n, 5);
    chk("lat3_rdata", d3_dbg_rdata, 16'h5A40);
    chk("lat3_cpu_rdata", d3_cpu_rdata, 16'h0000);
    @(negedge clk);
    chk("lat3_idle", {d3_busy, d3_dbg_ack}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
